instr_encoder: RTL
==================

# instr_encoder

Sequential RV32I instruction builder: accepts decoded instruction fields over a valid/ready handshake and encodes them into 32-bit machine words. It writes each word into instruction memory at an auto-incrementing word address. It sits on the program-load path ahead of the instruction memory and produces exactly the opcode set our main decoder consumes: R, I-ALU, LW, SW, B, LUI, JAL. Uses: boot loading, self-test program generation, bench stimulus.

## Interface
- ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W words
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: load write pointer, clear count/err, enter RUN
- start_addr  in  ADDR_W  first word address, sampled on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder accepts bundle this cycle
- in_kind  in  3  0 R, 1 I-ALU, 2 LW, 3 SW, 4 B, 5 LUI, 6 JAL, 7 illegal
- in_funct3  in  3  funct3 (R, I, B only)
- in_funct7  in  7  funct7 (R only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  byte-offset immediate, signed; LUI: full upper value
- mem_we  out  1  write word valid
- mem_ready  in  1  memory accepts write when mem_we=1
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words accepted since start
- full  out  1  count == DEPTH (non-wrap build)
- err  out  1  sticky encode error since start

## Operation
- FSM: IDLE (reset) -> RUN on start; RUN -> FULL when count reaches DEPTH; start in any state -> RUN.
- in_ready = (state==RUN) && !start && (!mem_we || mem_ready). IDLE and FULL: in_ready=0.
- Accept (in_valid && in_ready): encode, load output register with word and wr_ptr, then wr_ptr+1 (mod DEPTH) and count+1.
- Encodings:
  - R: {f7,rs2,rs1,f3,rd,0110011}
  - I: {imm[11:0],rs1,f3,rd,0010011}
  - LW: {imm[11:0],rs1,010,rd,0000011}
  - SW: {imm[11:5],rs2,rs1,010,imm[4:0],0100011}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}
  - LUI: {imm[31:12],rd,0110111}
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}
  - Unused fields ignored.
- err set (word still written) when:
  - I/LW/SW: imm not a 12-bit signed value (imm[31:11] not uniform);
  - B: not 13-bit signed, or imm[0]=1;
  - JAL: not 21-bit signed, or imm[0]=1;
  - LUI: imm[11:0]!=0;
  - kind 7: word forced to 0x00000013 (nop).
- Truncation is by bit slicing per format.
- Address wraps DEPTH-1 -> 0 in all builds.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, err 0, state IDLE, wr_ptr 0.
- Latency: accept in cycle N -> mem_we=1 with word in N+1.
- Throughput: 1 word/cycle while mem_ready=1.
- Stall: mem_we=1 && mem_ready=0 holds mem_addr/mem_wdata stable and drops in_ready. Accept and drain in the same cycle is allowed.
- mem_we falls the cycle after the handshake unless a new word was accepted.
- start does not cancel a pending output word: it completes at its original address. Input accept is blocked during the start cycle. wr_ptr/count/err update on the next edge.
- err and full update on the edge after the causing accept.
- rst_n low mid-stall: pending word dropped, all outputs to reset values.

## Configuration
- INSTR_ENC_WRAP_EN defined:
  - FULL state removed; full tied 0.
  - count saturates at DEPTH.
  - Accepts continue, overwriting from wrapped addresses.
- Not defined: entering FULL blocks input until next start.

## Test plan
- Reset, start with start_addr=0, R kind f7=0 f3=0 rd=3 rs1=1 rs2=2 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x002081B3, count=1.
- JAL rd=1 imm=8 -> mem_wdata=0x008000EF. B f3=0 rs1=rs2=0 imm=-4 with mem_ready low 3 cycles -> 0xFE000EE3 held stable, in_ready=0 throughout.
- I f3=0 rd=1 rs1=0 imm=2048 -> mem_wdata=0x80000093, err=1. kind 7 -> 0x00000013, err stays 1. Subsequent start clears err.
- ADDR_W=2, start_addr=2, four back-to-back LW words -> addresses 2,3,0,1. Without the macro, full=1 and in_ready=0. With INSTR_ENC_WRAP_EN, fifth word goes to address 2 and count stays 4.
- start_addr=5 pulse while a word to address 1 is stalled -> word writes at 1 when mem_ready rises. Next accepted word writes at 5 and count=1.
- rst_n low during stall -> mem_we=0, count=0, state IDLE, in_ready=0 until start.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: sequential RV32I instruction builder for the program-load path.
// Takes decoded field bundles over a valid/ready handshake, encodes each one into a
// 32-bit machine word, and writes it into instruction memory at an auto-incrementing
// word address. Supported kinds: R, I-ALU, LW, SW, B, LUI, JAL; kind 7 becomes a nop.
//
// Optional build macro: INSTR_ENC_WRAP_EN
//   undefined (default): the FULL state blocks input once DEPTH words are accepted,
//                        until the next start.
//   defined            : no FULL state, full tied 0, count saturates at DEPTH, and
//                        accepts continue, overwriting from wrapped addresses.
//
// Handshakes:
//   input : a bundle transfers on a rising edge where in_valid && in_ready. in_ready
//           never depends on in_valid. It is high only in RUN, outside a start cycle,
//           and when the output register is empty or draining this cycle.
//   output: a word transfers on a rising edge where mem_we && mem_ready. While
//           mem_we=1 and mem_ready=0, mem_addr and mem_wdata are held stable.
//   An accept and a drain may fall on the same edge.

module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        state_o
);

  // Word count value meaning "every address written once since start".
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_IALU = 3'd1;
  localparam logic [2:0] K_LW   = 3'd2;
  localparam logic [2:0] K_SW   = 3'd3;
  localparam logic [2:0] K_B    = 3'd4;
  localparam logic [2:0] K_LUI  = 3'd5;
  localparam logic [2:0] K_JAL  = 3'd6;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic                accept;
  logic                drain;
  logic [31:0]         enc_word;
  logic                enc_err;
  logic                imm12_ok;
  logic                imm13_ok;
  logic                imm21_ok;
  logic [ADDR_W:0]     count_inc;

  // Immediate range checks: a value fits N signed bits when bits [31:N-1]
  // are all equal (pure sign extension).
  assign imm12_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign imm13_ok = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign imm21_ok = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  assign in_ready  = (state_q == S_RUN) && !start && (!mem_we_q || mem_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = mem_we_q && mem_ready;
  assign count_inc = count_q + (ADDR_W + 1)'(1);

  // Field-to-word encoding; the word is still produced for out-of-range
  // immediates (truncated by slicing), only err flags the problem.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    case (in_kind)
      K_R: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      end
      K_IALU: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
        enc_err  = !imm12_ok;
      end
      K_LW: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LW};
        enc_err  = !imm12_ok;
      end
      K_SW: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_SW};
        enc_err  = !imm12_ok;
      end
      K_B: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], OP_B};
        enc_err  = !imm13_ok || in_imm[0];
      end
      K_LUI: begin
        enc_word = {in_imm[31:12], in_rd, OP_LUI};
        enc_err  = (in_imm[11:0] != 12'd0);
      end
      K_JAL: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, OP_JAL};
        enc_err  = !imm21_ok || in_imm[0];
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Next-state logic: start always (re)enters RUN; the last free slot moves to FULL.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
`ifndef INSTR_ENC_WRAP_EN
          if (accept && (count_inc == DEPTH_CNT)) begin
            state_d = S_FULL;
          end
`endif
        end
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: output word register, write pointer, count, sticky error.
  // A pending word survives start and finishes at the address it was given.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_ptr_q;
      mem_wdata_d = enc_word;
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
`ifdef INSTR_ENC_WRAP_EN
      if (count_q != DEPTH_CNT) begin
        count_d = count_inc;
      end
`else
      count_d = count_inc;
`endif
      if (enc_err) begin
        err_d = 1'b1;
      end
    end else if (drain) begin
      mem_we_d = 1'b0;
    end

    // accept is already blocked during start, so these never collide with it
    if (start) begin
      wr_ptr_d = start_addr;
      count_d  = '0;
      err_d    = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign state_o   = state_q;

`ifdef INSTR_ENC_WRAP_EN
  assign full = 1'b0;
`else
  assign full = (state_q == S_FULL);
`endif

endmodule
